// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/memory-handshake inputs and every datapath control strobe of the sequencer.
interface control_sequencer_if #(parameter int OPW = 5);
    logic [OPW-1:0] ir_op;
    logic mem_rdy;
    logic pc_out, zlow_out, zhigh_out, mdr_out, c_out, ba_out, r_out, lo_out, hi_out, in_port_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, hi_in, lo_in, c_in, in_in, out_in, z_in, con_in, r_in;
    logic gra, grb, grc, read, write, add, subtract, multiply, divide;
    logic run, err;
    logic [4:0] state;
    modport master (
        input ir_op, mem_rdy,
        output pc_out, zlow_out, zhigh_out, mdr_out, c_out, ba_out, r_out, lo_out, hi_out, in_port_out,
        output mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, hi_in, lo_in, c_in, in_in, out_in, z_in, con_in, r_in,
        output gra, grb, grc, read, write, add, subtract, multiply, divide,
        output run, err, state
    );
    modport slave (
        output ir_op, mem_rdy,
        input pc_out, zlow_out, zhigh_out, mdr_out, c_out, ba_out, r_out, lo_out, hi_out, in_port_out,
        input mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, hi_in, lo_in, c_in, in_in, out_in, z_in, con_in, r_in,
        input gra, grb, grc, read, write, add, subtract, multiply, divide,
        input run, err, state
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore fetch/decode/execute sequencer with memory wait, timeout and halt.
// Define CU_MULDIV_EN to decode mul/div; otherwise those opcodes behave as nop.
module control_sequencer #(
    parameter int OPW          = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input logic clk,
    input logic clr,
    control_sequencer_if.master bus
);
`ifdef CU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    typedef enum logic [4:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef enum logic [2:0] {C_NOP, C_LD, C_LDI, C_ST, C_ADD, C_SUB, C_MUL, C_DIV} cls_t;
    state_t st, nxt;
    cls_t cls, cls_d;
    logic [CW-1:0] cnt;
    logic err_q, mem_st, timeout, halt_op, ld_like, arith, md;
    always_comb begin
        cls_d = bus.ir_op == OPW'(0)  ? C_LD  :
                bus.ir_op == OPW'(1)  ? C_LDI :
                bus.ir_op == OPW'(2)  ? C_ST  :
                bus.ir_op == OPW'(3)  ? C_ADD :
                bus.ir_op == OPW'(4)  ? C_SUB :
                (MULDIV && bus.ir_op == OPW'(15)) ? C_MUL :
                (MULDIV && bus.ir_op == OPW'(16)) ? C_DIV : C_NOP;
        halt_op = bus.ir_op == OPW'(27);
        mem_st  = st == T1 || (st == T6 && cls == C_LD) || (st == T7 && cls == C_ST);
        timeout = mem_st && !bus.mem_rdy && cnt == CW'(MEM_WAIT_MAX - 1);
        ld_like = cls == C_LD || cls == C_LDI || cls == C_ST;
        arith   = cls == C_ADD || cls == C_SUB;
        md      = cls == C_MUL || cls == C_DIV;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            st    <= RST;
            cls   <= C_NOP;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            st  <= nxt;
            cnt <= (mem_st && !bus.mem_rdy) ? cnt + 1'b1 : '0;
            if (timeout) err_q <= 1'b1;
            if (st == T2) cls <= cls_d;
        end
    end
    always_comb begin
        nxt = st;
        case (st)
            RST:     nxt = T0;
            T0:      nxt = T1;
            T1:      nxt = T2;
            T2:      nxt = halt_op ? HALT : (cls_d == C_NOP ? T0 : T3);
            T3:      nxt = T4;
            T4:      nxt = T5;
            T5:      nxt = (cls == C_LD || cls == C_ST || md) ? T6 : T0;
            T6:      nxt = (cls == C_LD || cls == C_ST) ? T7 : T0;
            T7:      nxt = T0;
            default: nxt = st;
        endcase
        // a memory state holds until mem_rdy, unless the wait budget runs out
        if (mem_st && !bus.mem_rdy) nxt = timeout ? HALT : st;
    end
    assign bus.lo_out      = 1'b0;
    assign bus.hi_out      = 1'b0;
    assign bus.in_port_out = 1'b0;
    assign bus.c_in        = 1'b0;
    assign bus.in_in       = 1'b0;
    assign bus.out_in      = 1'b0;
    assign bus.con_in      = 1'b0;
    assign bus.run         = st != RST && st != HALT;
    assign bus.err         = err_q;
    assign bus.state       = st;
    always_comb begin
        {bus.pc_out, bus.zlow_out, bus.zhigh_out, bus.mdr_out, bus.c_out, bus.ba_out, bus.r_out} = '0;
        {bus.mar_in, bus.pc_in, bus.mdr_in, bus.ir_in, bus.y_in, bus.inc_pc, bus.hi_in, bus.lo_in} = '0;
        {bus.z_in, bus.r_in, bus.gra, bus.grb, bus.grc, bus.read, bus.write} = '0;
        {bus.add, bus.subtract, bus.multiply, bus.divide} = '0;
        case (st)
            T0: {bus.pc_out, bus.mar_in, bus.inc_pc, bus.z_in} = '1;
            T1: {bus.zlow_out, bus.pc_in, bus.read, bus.mdr_in} = '1;
            T2: {bus.mdr_out, bus.ir_in} = '1;
            T3: begin
                bus.y_in   = 1'b1;
                bus.grb    = ld_like || arith;
                bus.ba_out = ld_like;
                bus.gra    = md;
                bus.r_out  = arith || md;
            end
            T4: begin
                bus.z_in     = 1'b1;
                bus.c_out    = ld_like;
                bus.add      = ld_like || cls == C_ADD;
                bus.subtract = cls == C_SUB;
                bus.grc      = arith;
                bus.grb      = md;
                bus.r_out    = arith || md;
                bus.multiply = cls == C_MUL;
                bus.divide   = cls == C_DIV;
            end
            T5: begin
                bus.zlow_out = 1'b1;
                bus.mar_in   = cls == C_LD || cls == C_ST;
                bus.gra      = cls == C_LDI || arith;
                bus.r_in     = cls == C_LDI || arith;
                bus.lo_in    = md;
            end
            T6: begin
                bus.read      = cls == C_LD;
                bus.mdr_in    = cls == C_LD || cls == C_ST;
                bus.gra       = cls == C_ST;
                bus.r_out     = cls == C_ST;
                bus.zhigh_out = md;
                bus.hi_in     = md;
            end
            T7: begin
                bus.mdr_out = 1'b1;
                bus.gra     = cls == C_LD;
                bus.r_in    = cls == C_LD;
                bus.write   = cls == C_ST;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction streams checked against a per-instruction micro-step table.
module tb_control_sequencer;
`ifdef CU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int PCO = 0, ZLO = 1, ZHO = 2, MDRO = 3, CO = 4, BAO = 5, RO = 6;
    localparam int MARI = 10, PCI = 11, MDRI = 12, IRI = 13, YI = 14, INC = 15, HII = 16, LOI = 17;
    localparam int ZI = 21, RI = 23, GRA = 24, GRB = 25, GRC = 26, RD = 27, WR = 28;
    localparam int ADDS = 29, SUBS = 30, MULS = 31, DIVS = 32;
    localparam int NOP = 0, LD = 1, LDI = 2, ST = 3, ADD = 4, SUB = 5, MUL = 6, DIV = 7, HLT = 8;
    logic clk = 1'b0, clr = 1'b1;
    int n_chk = 0, n_fail = 0;
    control_sequencer_if #(.OPW(5)) bus ();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus.master));
    always #5 clk = ~clk;
    logic [32:0] obs;
    assign obs = {bus.divide, bus.multiply, bus.subtract, bus.add, bus.write, bus.read, bus.grc, bus.grb,
                  bus.gra, bus.r_in, bus.con_in, bus.z_in, bus.out_in, bus.in_in, bus.c_in, bus.lo_in,
                  bus.hi_in, bus.inc_pc, bus.y_in, bus.ir_in, bus.mdr_in, bus.pc_in, bus.mar_in,
                  bus.in_port_out, bus.hi_out, bus.lo_out, bus.r_out, bus.ba_out, bus.c_out,
                  bus.mdr_out, bus.zhigh_out, bus.zlow_out, bus.pc_out};
    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [32:0] b(input int p);
        return 33'(1) << p;
    endfunction
    function automatic int cls_of(input logic [4:0] op);
        case (op)
            5'd0:    return LD;
            5'd1:    return LDI;
            5'd2:    return ST;
            5'd3:    return ADD;
            5'd4:    return SUB;
            5'd15:   return MD ? MUL : NOP;
            5'd16:   return MD ? DIV : NOP;
            5'd27:   return HLT;
            default: return NOP;
        endcase
    endfunction
    function automatic int n_steps(input int c);
        case (c)
            LD, ST:   return 8;
            MUL, DIV: return 7;
            LDI, ADD, SUB: return 6;
            default:  return 3;
        endcase
    endfunction
    function automatic bit is_mem(input int c, input int k);
        return k == 1 || (c == LD && k == 6) || (c == ST && k == 7);
    endfunction
    function automatic logic [32:0] exp_stb(input int c, input int k);
        if (k == 0) return b(PCO) | b(MARI) | b(INC) | b(ZI);
        if (k == 1) return b(ZLO) | b(PCI) | b(RD) | b(MDRI);
        if (k == 2) return b(MDRO) | b(IRI);
        if (c == LD || c == LDI || c == ST) begin
            if (k == 3) return b(GRB) | b(BAO) | b(YI);
            if (k == 4) return b(CO) | b(ADDS) | b(ZI);
        end
        if (c == ADD || c == SUB) begin
            if (k == 3) return b(GRB) | b(RO) | b(YI);
            if (k == 4) return b(GRC) | b(RO) | b(c == ADD ? ADDS : SUBS) | b(ZI);
            if (k == 5) return b(ZLO) | b(GRA) | b(RI);
        end
        if (c == MUL || c == DIV) begin
            if (k == 3) return b(GRA) | b(RO) | b(YI);
            if (k == 4) return b(GRB) | b(RO) | b(c == MUL ? MULS : DIVS) | b(ZI);
            if (k == 5) return b(ZLO) | b(LOI);
            if (k == 6) return b(ZHO) | b(HII);
        end
        if (c == LDI && k == 5) return b(ZLO) | b(GRA) | b(RI);
        if ((c == LD || c == ST) && k == 5) return b(ZLO) | b(MARI);
        if (c == LD && k == 6) return b(RD) | b(MDRI);
        if (c == LD && k == 7) return b(MDRO) | b(GRA) | b(RI);
        if (c == ST && k == 6) return b(GRA) | b(RO) | b(MDRI);
        if (c == ST && k == 7) return b(MDRO) | b(WR);
        return '0;
    endfunction
    task automatic check_idle(input logic e);
        chk("stb_idle", obs, '0);
        chk("run_idle", 33'(bus.run), '0);
        chk("err_idle", 33'(bus.err), 33'(e));
    endtask
    task automatic do_reset;
        clr = 1'b1;
        tick;
        check_idle(1'b0);
        tick;
        check_idle(1'b0);
        clr = 1'b0;
        tick;
    endtask
    task automatic check_halt(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            bus.mem_rdy = 1'($urandom);
            bus.ir_op   = 5'($urandom);
            check_idle(e);
            tick;
        end
    endtask
    task automatic run_instr(input logic [4:0] op, input int wlo, input int whi, input int stop);
        int c, n, w;
        c = cls_of(op);
        n = n_steps(c) < stop ? n_steps(c) : stop;
        for (int k = 0; k < n; k++) begin
            w = is_mem(c, k) ? int'($urandom_range(whi, wlo)) : 0;
            for (int j = 0; j <= w; j++) begin
                bus.mem_rdy = is_mem(c, k) ? (j == w) : 1'($urandom);
                bus.ir_op   = k == 2 ? op : 5'($urandom);
                chk($sformatf("stb op%0d k%0d", op, k), obs, exp_stb(c, k));
                chk("run", 33'(bus.run), 33'(1));
                chk("err", 33'(bus.err), '0);
                tick;
            end
        end
    endtask
    task automatic timeout_t1;
        bus.mem_rdy = 1'b1;
        chk("stb_to_t0", obs, exp_stb(NOP, 0));
        tick;
        for (int i = 0; i < 15; i++) begin
            bus.mem_rdy = 1'b0;
            chk("stb_to_t1", obs, exp_stb(NOP, 1));
            chk("err_to_wait", 33'(bus.err), '0);
            tick;
        end
        check_halt(5, 1'b1);
    endtask
    initial begin
        logic [4:0] ops [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd15, 5'd16, 5'd26, 5'd27};
        logic [4:0] op;
        bus.mem_rdy = 1'b1;
        bus.ir_op   = '0;
        do_reset;
        run_instr(5'd0, 0, 0, 8);
        run_instr(5'd3, 0, 0, 8);
        run_instr(5'd4, 0, 0, 8);
        run_instr(5'd15, 0, 0, 8);
        run_instr(5'd16, 0, 0, 8);
        run_instr(5'd1, 0, 0, 8);
        run_instr(5'd2, 0, 0, 8);
        run_instr(5'd26, 3, 3, 8);
        run_instr(5'd0, 14, 14, 8);
        run_instr(5'd2, 14, 14, 8);
        run_instr(5'd21, 0, 0, 8);
        timeout_t1;
        do_reset;
        run_instr(5'd27, 0, 0, 8);
        check_halt(20, 1'b0);
        do_reset;
        run_instr(5'd0, 0, 0, 5);
        clr = 1'b1;
        chk("stb_ld_t5", obs, exp_stb(LD, 5));
        tick;
        check_idle(1'b0);
        clr = 1'b0;
        tick;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(40, 0) == 0) begin
                timeout_t1;
                do_reset;
            end else begin
                op = $urandom_range(9, 0) == 9 ? 5'($urandom) : ops[$urandom_range(8, 0)];
                run_instr(op, 0, $urandom_range(3, 0) == 0 ? 14 : 0, 8);
                if (cls_of(op) == HLT) begin
                    check_halt(3, 1'b0);
                    do_reset;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
